// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF inference run controller.
package lif_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int CLEAR_CYCLES_DEF = 2;
  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/lif_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module lif_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lif_run_controller.sv
// Inference sequencer: clear, drive stimulus for N steps, drain,
// then hand back spike count and first-spike step.
module lif_run_controller
  import lif_pkg::*;
#(
  parameter int STEPS_W      = 8,
  parameter int CNT_W        = 8,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [7:0]         stim,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic               abort,
  output logic [7:0]         net_current,
  output logic               net_rst_n,
  input  logic               net_spike,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   spike_count,
  output logic [STEPS_W:0]   first_spike_step,
  output logic               busy
);

  localparam int CW   = $clog2(CLEAR_CYCLES + DRAIN_CYCLES + 1);
  localparam int PH_W = (STEPS_W > CW) ? STEPS_W : CW;

  state_e             state_q, state_d;
  logic [7:0]         stim_q, stim_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [7:0]         cur_q, cur_d;
  logic               nrst_q, nrst_d;
  logic               rv_q, rv_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic [STEPS_W:0]   first_q, first_d;
  logic               seen_q, seen_d;
  logic [STEPS_W:0]   step_cnt;
  logic               accept;
  logic               counting;

  // Abort in IDLE blocks a simultaneous start.
  assign start_ready = rdy_q & ~abort;
  assign accept      = start_valid & start_ready;
  assign counting    = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    steps_d = steps_q;
    ph_d    = ph_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stim_d  = stim;
          steps_d = num_steps;
          ph_d    = PH_W'(CLEAR_CYCLES - 1);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (ph_q != '0) begin
          ph_d = ph_q - 1'b1;
        end else if (steps_q == '0) begin
          ph_d    = PH_W'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end else begin
          ph_d    = PH_W'(steps_q - 1'b1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ph_q != '0) begin
          ph_d = ph_q - 1'b1;
        end else begin
          ph_d    = PH_W'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ph_q != '0) begin
          ph_d = ph_q - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    first_d = first_q;
    seen_d  = seen_q;
    if (accept) begin
      first_d = '1;
      seen_d  = 1'b0;
    end else if (counting && net_spike && !seen_q) begin
      first_d = step_cnt;
      seen_d  = 1'b1;
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    cur_d  = (state_d == S_RUN) ? stim_d : 8'h00;
    nrst_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    rv_d   = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      steps_q <= '0;
      ph_q    <= '0;
      cur_q   <= '0;
      nrst_q  <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      first_q <= '1;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      steps_q <= steps_d;
      ph_q    <= ph_d;
      cur_q   <= cur_d;
      nrst_q  <= nrst_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      first_q <= first_d;
      seen_q  <= seen_d;
    end
  end

  lif_sat_counter #(.W(STEPS_W + 1)) u_step_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (counting),
    .cnt_o (step_cnt)
  );

  lif_sat_counter #(.W(CNT_W)) u_spike_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (counting & net_spike),
    .cnt_o (spike_count)
  );

  assign net_current      = cur_q;
  assign net_rst_n        = nrst_q;
  assign result_valid     = rv_q;
  assign busy             = busy_q;
  assign first_spike_step = first_q;

endmodule

// File: tb/tb_lif_run_controller.sv
// Directed bench for lif_run_controller: main instance plus a
// narrow-counter instance for spike-count saturation.
module tb_lif_run_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] stim;
  logic [7:0] num_steps;
  logic       abort;
  logic [7:0] net_current;
  logic       net_rst_n;
  logic       net_spike;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] spike_count;
  logic [8:0] first_spike_step;
  logic       busy;

  logic       s_start_valid;
  logic       s_start_ready;
  logic [7:0] s_stim;
  logic [7:0] s_num_steps;
  logic       s_abort;
  logic [7:0] s_net_current;
  logic       s_net_rst_n;
  logic       s_net_spike;
  logic       s_result_valid;
  logic       s_result_ready;
  logic [2:0] s_spike_count;
  logic [8:0] s_first_spike_step;
  logic       s_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_cnt = 0;
  int          tb_step = 0;
  logic [31:0] spike_mask = '0;
  logic        spike_hold = 1'b0;
  int          cyc;
  int          rv_seen;

  always #5 clk = ~clk;

  lif_run_controller dut (
    .clk              (clk),
    .rst              (rst),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .stim             (stim),
    .num_steps        (num_steps),
    .abort            (abort),
    .net_current      (net_current),
    .net_rst_n        (net_rst_n),
    .net_spike        (net_spike),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .spike_count      (spike_count),
    .first_spike_step (first_spike_step),
    .busy             (busy)
  );

  lif_run_controller #(.CNT_W(3)) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .start_valid      (s_start_valid),
    .start_ready      (s_start_ready),
    .stim             (s_stim),
    .num_steps        (s_num_steps),
    .abort            (s_abort),
    .net_current      (s_net_current),
    .net_rst_n        (s_net_rst_n),
    .net_spike        (s_net_spike),
    .result_valid     (s_result_valid),
    .result_ready     (s_result_ready),
    .spike_count      (s_spike_count),
    .first_spike_step (s_first_spike_step),
    .busy             (s_busy)
  );

  // Network stand-in: spike pattern indexed by run step.
  always @(negedge clk) begin
    if (net_current != 8'h00) cur_cnt++;
    if (net_rst_n) begin
      net_spike = spike_hold | spike_mask[tb_step[4:0]];
      tb_step++;
    end else begin
      net_spike = spike_hold;
      tb_step = 0;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] s, input logic [7:0] n,
                           input bit keep);
    @(negedge clk);
    cur_cnt     = 0;
    start_valid = 1'b1;
    stim        = s;
    num_steps   = n;
    @(posedge clk);
    #1;
    if (!keep) start_valid = 1'b0;
  endtask

  task automatic wait_rv(output int c);
    c = 1;
    while (!result_valid && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("cons_rv", result_valid, 0);
    expect_eq("cons_rdy", start_ready, 1);
    expect_eq("cons_busy", busy, 0);
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 0; stim = 0; num_steps = 0; abort = 0;
    result_ready = 0;
    s_start_valid = 0; s_stim = 0; s_num_steps = 0; s_abort = 0;
    s_net_spike = 1'b1; s_result_ready = 0;
    repeat (2) @(negedge clk);
    expect_eq("rst_rdy", start_ready, 1);
    expect_eq("rst_nrst", net_rst_n, 0);
    expect_eq("rst_cur", net_current, 0);
    expect_eq("rst_rv", result_valid, 0);
    expect_eq("rst_cnt", spike_count, 0);
    expect_eq("rst_first", first_spike_step, 9'h1FF);
    expect_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // Basic run, spikes on steps 2 and 6, result held for 4 cycles.
    spike_mask = 32'h0000_0044;
    start_run(8'hFF, 8'd5, 0);
    wait_rv(cyc);
    expect_eq("basic_lat", cyc, 11);
    expect_eq("basic_curcyc", cur_cnt, 5);
    expect_eq("basic_cnt", spike_count, 2);
    expect_eq("basic_first", first_spike_step, 2);
    expect_eq("basic_nrst", net_rst_n, 0);
    expect_eq("basic_rdy", start_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      expect_eq("hold_rv", result_valid, 1);
      expect_eq("hold_cnt", spike_count, 2);
      expect_eq("hold_first", first_spike_step, 2);
    end
    consume();

    // Zero steps, no spikes.
    spike_mask = '0;
    start_run(8'hAA, 8'd0, 0);
    wait_rv(cyc);
    expect_eq("zero_lat", cyc, 6);
    expect_eq("zero_curcyc", cur_cnt, 0);
    expect_eq("zero_cnt", spike_count, 0);
    expect_eq("zero_first", first_spike_step, 9'h1FF);
    consume();

    // start_valid held through the run: one result, then re-accept.
    start_run(8'h0F, 8'd3, 1);
    wait_rv(cyc);
    expect_eq("held_lat", cyc, 9);
    expect_eq("held_curcyc", cur_cnt, 3);
    consume();
    @(posedge clk);
    #1;
    expect_eq("reacc_busy", busy, 1);
    expect_eq("reacc_rdy", start_ready, 0);
    start_valid = 1'b0;
    wait_rv(cyc);
    expect_eq("reacc_lat", cyc, 9);
    consume();

    // Abort at RUN step 3.
    start_run(8'h33, 8'd10, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    expect_eq("abrt_pre_cur", net_current, 8'h33);
    abort = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("abrt_busy", busy, 0);
    expect_eq("abrt_nrst", net_rst_n, 0);
    expect_eq("abrt_cur", net_current, 0);
    expect_eq("abrt_rdy", start_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    expect_eq("abrt_norv", rv_seen, 0);

    // Abort together with start in IDLE.
    abort = 1'b1;
    start_valid = 1'b1;
    stim = 8'h77;
    num_steps = 8'd4;
    #1;
    expect_eq("ab_st_rdy", start_ready, 0);
    @(posedge clk);
    #1;
    expect_eq("ab_st_busy", busy, 0);
    abort = 1'b0;
    start_valid = 1'b0;

    // Asynchronous reset in the middle of RUN.
    start_run(8'h55, 8'd10, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("mid_cur", net_current, 8'h55);
    rst = 1'b1;
    #1;
    expect_eq("mrst_nrst", net_rst_n, 0);
    expect_eq("mrst_cur", net_current, 0);
    expect_eq("mrst_rv", result_valid, 0);
    expect_eq("mrst_rdy", start_ready, 1);
    expect_eq("mrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturating 3-bit spike counter, spike held high throughout.
    @(negedge clk);
    s_start_valid = 1'b1;
    s_stim = 8'h01;
    s_num_steps = 8'd20;
    @(posedge clk);
    #1;
    s_start_valid = 1'b0;
    cyc = 1;
    while (!s_result_valid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    expect_eq("sat_lat", cyc, 26);
    expect_eq("sat_cnt", s_spike_count, 7);
    expect_eq("sat_first", s_first_spike_step, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
